alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one `alu_16_bit` instance between two requesters, e.g. the PC/branch unit on port 0 and the register-file datapath on port 1. Each request presents A, B and op with a valid/ready handshake. The block grants round-robin, runs the operation on registered operands and returns a registered result with the requester ID. It sits between the processor control path and the single ALU, replacing direct ALU wiring.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; must equal the ALU width (16).
- `OPW`, 3, opcode width.

Ports:
- `CLK` in 1: sole clock; all state changes on the rising edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `req_valid` in 2: bit i means requester i presents an operation.
- `req_ready` out 2: bit i means requester i is accepted this cycle. One-hot or zero.
- `req0_A`, `req0_B` in WIDTH: requester 0 operands.
- `req0_op` in OPW: requester 0 opcode.
- `req1_A`, `req1_B` in WIDTH: requester 1 operands.
- `req1_op` in OPW: requester 1 opcode.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer takes the response.
- `resp_id` out 1: requester that owns the response.
- `resp_R` out WIDTH: ALU result.
- `resp_AltB` out 1: unsigned A<B for op 5; 0 for all other ops.

## Operation
- FSM states: IDLE, EXEC, RESP. Binary encoding.
- **IDLE**
  - `grant` is computed combinationally from `req_valid` and `last_id`:
    - One valid: that requester wins.
    - Both valid: the requester != `last_id` wins.
    - None valid: no grant.
  - `req_ready = grant` in IDLE only; it is 0 in every other state.
  - A handshake occurs on `req_valid[i] & req_ready[i]`. It captures A, B and op into operand registers, sets `id_q = i` and `last_id = i`, and moves to EXEC.
- **EXEC** (exactly 1 cycle)
  - The ALU is driven from the operand registers.
  - At the edge, capture:
    - `resp_R <= R`
    - `resp_AltB <= (op==5) ? AltB : 0`
    - `resp_id <= id_q`
  - Move to RESP.
  - The ALU's AltB output is undefined for ops other than 5, so it must never be forwarded unmasked.
- **RESP**
  - `resp_valid = 1`. `resp_R`, `resp_AltB` and `resp_id` are held stable.
  - On `resp_ready = 1`, move to IDLE.
  - No new request is accepted in the same cycle.
- Opcodes are passed through unchanged:
  - 0: AND
  - 1: OR
  - 2: ADD
  - 3: SUB
  - 4: SHIFT (B>0 left by B, B==0 pass, B<0 logical right by −B)
  - 5: SLT (R = A+B, AltB flag)
  - 6, 7: ADD
- Arithmetic wraps modulo 2^16. No carry or overflow outputs.
- A requester may drop `req_valid` without a handshake; nothing is captured.
- Operands are sampled only at the handshake edge. Later changes do not affect the in-flight operation.

## Timing
- Reset (`RST_N` = 0 at an edge):
  - state = IDLE, `last_id` = 1 (port 0 wins the first tie).
  - `resp_valid` = 0, `resp_R` = 0, `resp_AltB` = 0, `resp_id` = 0, `req_ready` = 0 during reset.
- Latency: handshake at edge N → `resp_valid` high in cycle N+2.
- Throughput: at most one operation per 3 cycles. Each extra `resp_ready` stall cycle adds 1.
- Reset mid-operation (EXEC or RESP): return to IDLE at the next edge. The in-flight response is discarded and never presented. `last_id` returns to 1.
- Both valid every cycle: grants alternate 0,1,0,1, … Neither requester waits more than one operation.
- `resp_ready` held high: RESP lasts exactly 1 cycle.
- `resp_ready` asserted outside RESP: ignored.

## Structure
- Shared package `alu_pkg` (Verilog header if the toolflow requires it) holds:
  - Opcode constants: `OP_AND`=0, `OP_OR`=1, `OP_ADD`=2, `OP_SUB`=3, `OP_SHIFT`=4, `OP_SLT`=5.
  - FSM state constants: `S_IDLE`, `S_EXEC`, `S_RESP`.
- One sub-module: `alu_16_bit`, instantiated unmodified and fed only from the operand registers.
- The grant logic stays inline; there is no separate arbiter module.

## Test plan
- **Reset.** Hold `RST_N` = 0 for 2 cycles with both valid.
  - Expect `req_ready` = 00, `resp_valid` = 0, `resp_R` = 0x0000.
  - After release, the first tie grants port 0.
- **Single ADD on port 1.** A=0x7FFF, B=0x0001, op=2.
  - `req_ready` = 10 in the handshake cycle.
  - Two cycles later: `resp_valid` = 1, `resp_id` = 1, `resp_R` = 0x8000, `resp_AltB` = 0.
- **Shift both directions.**
  - op=4, A=0x0F00, B=0xFFFC → `resp_R` = 0x00F0.
  - op=4, A=0x0F00, B=0x0004 → `resp_R` = 0xF000.
  - op=4, B=0 → `resp_R` = A.
- **SLT masking.**
  - op=5, A=0x0003, B=0x0005 → `resp_AltB` = 1, `resp_R` = 0x0008.
  - Next op=0, A=0x0003, B=0x0005 → `resp_AltB` = 0, `resp_R` = 0x0001.
- **Contention and backpressure.** Both valid continuously; hold `resp_ready` = 0 for 4 cycles, then 1.
  - Response stays stable (`resp_id` = 0) through the stall.
  - Subsequent grants alternate 1,0,1.
  - No second grant occurs while RESP is pending.
- **Reset mid-op.** Assert `RST_N` = 0 for one edge while in EXEC.
  - `resp_valid` never rises for that operation.
  - The FSM is in IDLE and the next tie grants port 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcode values and FSM states.
package alu_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_SHIFT = 3'd4;
    localparam logic [2:0] OP_SLT   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_16_bit.sv
// 16-bit combinational ALU; AltB is only meaningful for OP_SLT.
module alu_16_bit
    import alu_pkg::*;
(
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [2:0]  op,
    output logic [15:0] R,
    output logic        AltB
);

    logic [15:0] neg_b;

    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        R     = A + B;
        AltB  = (A < B);
        neg_b = -B;
        case (op)
            OP_AND: R = A & B;
            OP_OR:  R = A | B;
            OP_SUB: R = A - B;
            OP_SHIFT: begin
                // B is a signed shift count: positive shifts left, negative shifts right
                if (B == 16'h0000)
                    R = A;
                else if (B[15])
                    R = A >> neg_b;
                else
                    R = A << B;
            end
            default: R = A + B;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_16_bit between two requesters,
// with registered operands and a registered, held response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [OPW-1:0]   req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_R,
    output logic             resp_AltB
);

    state_t           state;
    logic             last_id;
    logic             id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OPW-1:0]   op_q;
    logic [1:0]       grant;
    logic [WIDTH-1:0] alu_r;
    logic             alu_altb;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11)
            grant = last_id ? 2'b01 : 2'b10;
    end

    assign req_ready  = (state == S_IDLE && RST_N) ? grant : 2'b00;
    assign resp_valid = (state == S_RESP);

    alu_16_bit u_alu (
        .A    (a_q),
        .B    (b_q),
        .op   (op_q),
        .R    (alu_r),
        .AltB (alu_altb)
    );

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge.
        if (!RST_N) begin
            state     <= S_IDLE;
            last_id   <= 1'b1;
            id_q      <= 1'b0;
            // NOTE: operand registers are reset too so the ALU never sees X
            // after power-up.
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            resp_R    <= '0;
            resp_AltB <= 1'b0;
            resp_id   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_ready != 2'b00) begin
                        id_q    <= req_ready[1];
                        last_id <= req_ready[1];
                        a_q     <= req_ready[1] ? req1_A  : req0_A;
                        b_q     <= req_ready[1] ? req1_B  : req0_B;
                        op_q    <= req_ready[1] ? req1_op : req0_op;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_R    <= alu_r;
                    // AltB from the ALU is undefined outside SLT
                    resp_AltB <= (op_q == OP_SLT) ? alu_altb : 1'b0;
                    resp_id   <= id_q;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_alu_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req0_A, req0_B, req1_A, req1_B;
    logic [2:0]  req0_op, req1_op;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [15:0] resp_R;
    logic        resp_AltB;

    int vectors     = 0;
    int miscompares = 0;

    // Model: 0 = free, 1 = operation in flight, 2 = response presented
    int          m_phase = 0;
    bit          m_last  = 1'b1;
    bit          m_id;
    logic [15:0] m_r;
    bit          m_altb;
    bit          dut_grants[$];

    always #5 CLK = ~CLK;

    alu_arbiter #(.WIDTH(16), .OPW(3)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_A     (req0_A),
        .req0_B     (req0_B),
        .req0_op    (req0_op),
        .req1_A     (req1_A),
        .req1_B     (req1_B),
        .req1_op    (req1_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_R     (resp_R),
        .resp_AltB  (resp_AltB)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result from the opcode rules, with shifts done as multiply/divide by powers of two.
    function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op);
        int          sb;
        logic [15:0] r;
        logic        lt;
        sb = int'($signed(b));
        lt = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd3: r = a - b;
            3'd4: begin
                if (sb == 0)
                    r = a;
                else if (sb > 0)
                    r = (sb >= 16) ? 16'h0000 : 16'(longint'(a) * (longint'(1) << sb));
                else
                    r = (-sb >= 16) ? 16'h0000 : 16'(longint'(a) / (longint'(1) << (-sb)));
            end
            3'd5: begin
                r  = a + b;
                lt = (a < b);
            end
            default: r = a + b;
        endcase
        return {lt, r};
    endfunction

    // Compare the DUT against the model, then advance the model across the coming edge.
    task automatic model_cycle();
        logic [1:0]  g;
        logic [16:0] res;
        g = 2'b00;
        if (m_phase == 0 && RST_N) begin
            if (req_valid == 2'b11)
                g = m_last ? 2'b01 : 2'b10;
            else
                g = req_valid;
        end
        check("req_ready", {30'd0, req_ready}, {30'd0, g});
        check("resp_valid", {31'd0, resp_valid}, {31'd0, m_phase == 2});
        if (m_phase == 2) begin
            check("resp_id", {31'd0, resp_id}, {31'd0, m_id});
            check("resp_R", {16'd0, resp_R}, {16'd0, m_r});
            check("resp_AltB", {31'd0, resp_AltB}, {31'd0, m_altb});
        end
        if (req_ready != 2'b00)
            dut_grants.push_back(req_ready[1]);
        if (!RST_N) begin
            m_phase = 0;
            m_last  = 1'b1;
        end else if (m_phase == 0) begin
            if (g != 2'b00) begin
                m_id    = g[1];
                m_last  = g[1];
                res     = g[1] ? ref_alu(req1_A, req1_B, req1_op) : ref_alu(req0_A, req0_B, req0_op);
                m_r     = res[15:0];
                m_altb  = res[16];
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (resp_ready) begin
            m_phase = 0;
        end
    endtask

    task automatic neg();
        @(negedge CLK);
    endtask

    task automatic fin();
        model_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc();
        neg();
        fin();
    endtask

    function automatic logic [15:0] rand_b(input logic [2:0] op);
        if (op == 3'd4 && $urandom_range(0, 3) != 0)
            return 16'($urandom_range(0, 40)) - 16'd20;
        return 16'($urandom);
    endfunction

    task automatic rand_ops();
        req0_op = 3'($urandom_range(0, 7));
        req1_op = 3'($urandom_range(0, 7));
        req0_A  = 16'($urandom);
        req1_A  = 16'($urandom);
        req0_B  = rand_b(req0_op);
        req1_B  = rand_b(req1_op);
    endtask

    task automatic drain();
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        for (int i = 0; i < 6 && m_phase != 0; i++)
            cyc();
        check("drain_idle", m_phase, 0);
    endtask

    // Single operation on one port with literal expectations on the response.
    task automatic run_op(input string name, input bit port, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] op,
                          input logic [15:0] exp_r, input bit exp_altb);
        drain();
        rand_ops();
        if (port) begin
            req1_A = a; req1_B = b; req1_op = op;
        end else begin
            req0_A = a; req0_B = b; req0_op = op;
        end
        req_valid  = port ? 2'b10 : 2'b01;
        resp_ready = 1'b1;
        neg();
        check({name, "_ready"}, {30'd0, req_ready}, port ? 32'd2 : 32'd1);
        fin();
        req_valid = 2'b00;
        rand_ops();
        neg();
        check({name, "_exec"}, {31'd0, resp_valid}, 32'd0);
        fin();
        rand_ops();
        neg();
        check({name, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({name, "_id"}, {31'd0, resp_id}, {31'd0, port});
        check({name, "_R"}, {16'd0, resp_R}, {16'd0, exp_r});
        check({name, "_AltB"}, {31'd0, resp_AltB}, {31'd0, exp_altb});
        fin();
    endtask

    initial begin
        RST_N      = 1'b0;
        req_valid  = 2'b11;
        resp_ready = 1'b0;
        rand_ops();
        @(posedge CLK);
        #1;

        // Reset held with both requesters valid
        for (int i = 0; i < 2; i++) begin
            neg();
            check("rst_ready", {30'd0, req_ready}, 32'd0);
            check("rst_valid", {31'd0, resp_valid}, 32'd0);
            check("rst_R", {16'd0, resp_R}, 32'd0);
            fin();
        end

        // First tie goes to port 0, then the response is stalled for 4 cycles
        RST_N = 1'b1;
        neg();
        check("tie0_ready", {30'd0, req_ready}, 32'd1);
        fin();
        rand_ops();
        cyc();
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            neg();
            check("stall_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_id", {31'd0, resp_id}, 32'd0);
            check("stall_ready", {30'd0, req_ready}, 32'd0);
            fin();
        end
        resp_ready = 1'b1;
        cyc();
        dut_grants.delete();
        for (int i = 0; i < 9; i++) begin
            rand_ops();
            cyc();
        end
        check("alt_count", dut_grants.size(), 3);
        if (dut_grants.size() >= 3) begin
            check("alt_g0", {31'd0, dut_grants[0]}, 32'd1);
            check("alt_g1", {31'd0, dut_grants[1]}, 32'd0);
            check("alt_g2", {31'd0, dut_grants[2]}, 32'd1);
        end

        run_op("add1",  1'b1, 16'h7FFF, 16'h0001, 3'd2, 16'h8000, 1'b0);
        run_op("shr",   1'b0, 16'h0F00, 16'hFFFC, 3'd4, 16'h00F0, 1'b0);
        run_op("shl",   1'b1, 16'h0F00, 16'h0004, 3'd4, 16'hF000, 1'b0);
        run_op("sh0",   1'b0, 16'h1234, 16'h0000, 3'd4, 16'h1234, 1'b0);
        run_op("slt",   1'b0, 16'h0003, 16'h0005, 3'd5, 16'h0008, 1'b1);
        run_op("andm",  1'b0, 16'h0003, 16'h0005, 3'd0, 16'h0001, 1'b0);
        run_op("sub",   1'b1, 16'h0000, 16'h0001, 3'd3, 16'hFFFF, 1'b0);

        // Reset while the operation is executing
        drain();
        rand_ops();
        req_valid = 2'b01;
        cyc();
        RST_N     = 1'b0;
        req_valid = 2'b00;
        cyc();
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            neg();
            check("midrst_valid", {31'd0, resp_valid}, 32'd0);
            fin();
        end
        req_valid = 2'b11;
        neg();
        check("midrst_tie", {30'd0, req_ready}, 32'd1);
        fin();

        // Randomized traffic with backpressure and occasional resets
        for (int i = 0; i < 3000; i++) begin
            rand_ops();
            req_valid  = 2'($urandom_range(0, 3));
            resp_ready = ($urandom_range(0, 9) < 7);
            RST_N      = ($urandom_range(0, 149) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
